// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: FSM states, port-owner codes and
// the arbitration helper used by the top.
package mem_arbiter_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  // Data wins a tie unless prefer_if is set; a lone request always wins.
  function automatic logic pick_owner(input logic if_req, input logic d_req,
                                      input logic prefer_if);
    return (if_req && (!d_req || prefer_if)) ? OWN_IF : OWN_D;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Saturating BUSY-cycle counter. expired_o is high on the TIMEOUT-th
// consecutive enabled cycle.
module mem_arb_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] Sat  = CW'(TIMEOUT);
  localparam logic [CW-1:0] Last = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  // Next count: clear wins, otherwise count up and stick at TIMEOUT.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != Sat)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  // count_q holds cycles already spent, so the current cycle is count_q + 1.
  assign expired_o = en_i && (count_q >= Last);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port memory.
// One transaction in flight: IDLE -> BUSY -> RESP -> IDLE.
// Define MEM_ARB_FAIRNESS_EN to alternate on simultaneous requests;
// otherwise the data port always wins a tie.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ready,
  input  logic [DW-1:0]   mem_rdata,
  output logic            err
);

  logic [1:0]      state_q, state_d;
  logic            owner_q, owner_d;
  logic            if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
  logic            if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic            mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW/8-1:0] mem_be_q, mem_be_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic            err_q, err_d;
  logic            win;
  logic            expired;

`ifdef MEM_ARB_FAIRNESS_EN
  logic last_q;

  // Remember who was granted last; reset value lets data win the first tie.
  always_ff @(posedge clk) begin
    if (rst)                                     last_q <= OWN_IF;
    else if ((state_q == IDLE) && (if_req || d_req)) last_q <= win;
  end

  assign win = pick_owner(if_req, d_req, last_q == OWN_D);
`else
  assign win = pick_owner(if_req, d_req, 1'b0);
`endif

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .clear_i   (state_q != BUSY),
    .en_i      (state_q == BUSY),
    .expired_o (expired)
  );

  // FSM next state, command latch, response capture and pulse generation.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          state_d   = BUSY;
          owner_d   = win;
          mem_req_d = 1'b1;
          if (win == OWN_D) begin
            d_gnt_d     = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_be_d    = d_be;
          end else begin
            if_gnt_d    = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_be_d    = '1;
          end
        end
      end
      BUSY: begin
        // A completion on the last allowed cycle still counts as success.
        if (mem_ready) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (owner_q == OWN_D) d_rdata_d  = mem_rdata;
          else                  if_rdata_d = mem_rdata;
        end else if (expired) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (owner_q == OWN_D) d_rvalid_d  = 1'b1;
        else                  if_rvalid_d = 1'b1;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch read, data write, tie arbitration,
// timeout and reset-abort. Arbitration expectations follow MEM_ARB_FAIRNESS_EN.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
  logic [3:0]    d_be = '0;
  logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, err;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  mem_arbiter #(
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [1:0] exp_order [4];
  logic       got;

  initial begin
`ifdef MEM_ARB_FAIRNESS_EN
    exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_order = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

    // Reset state
    do_reset();
    check_eq("rst_outs", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we, err}, 7'b0);
    check_eq("rst_addr", mem_addr, 32'h0);
    check_eq("rst_rdata", {if_rdata, d_rdata}, 64'h0);

    // Fetch read, ready in first BUSY cycle
    if_req = 1'b1; if_addr = 32'h0000_0010;
    tick();                                    // cycle 1
    check_eq("fetch_gnt", {if_gnt, d_gnt, mem_req, mem_we}, 4'b1010);
    check_eq("fetch_addr", mem_addr, 32'h0000_0010);
    check_eq("fetch_be", mem_be, 4'hF);
    if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
    tick();                                    // cycle 2
    mem_ready = 1'b0;
    check_eq("fetch_c2", {if_gnt, if_rvalid, mem_req}, 3'b000);
    tick();                                    // cycle 3
    check_eq("fetch_rvalid", {if_rvalid, d_rvalid}, 2'b10);
    check_eq("fetch_rdata", if_rdata, 32'h0050_0093);
    tick();
    check_eq("fetch_pulse", if_rvalid, 1'b0);
    check_eq("fetch_hold", if_rdata, 32'h0050_0093);

    // Data write
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0040; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF;
    tick();
    check_eq("wr_gnt", {if_gnt, d_gnt, mem_req, mem_we}, 4'b0111);
    check_eq("wr_cmd", {mem_addr, mem_wdata}, {32'h0000_0040, 32'hDEAD_BEEF});
    check_eq("wr_be", mem_be, 4'hF);
    d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0;
    tick();
    mem_ready = 1'b0;
    tick();
    check_eq("wr_rvalid", {if_rvalid, d_rvalid}, 2'b01);
    tick();
    check_eq("wr_pulse", d_rvalid, 1'b0);

    // Simultaneous requests held for four transactions
    do_reset();
    if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_addr = 32'h200;
    for (int t = 0; t < 4; t++) begin
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        tick();
        if (if_gnt || d_gnt) got = 1'b1;
      end
      check_eq("arb_seen", got, 1'b1);
      check_eq($sformatf("arb_order%0d", t), {if_gnt, d_gnt}, exp_order[t]);
      mem_ready = 1'b1; mem_rdata = DW'(t);
      tick();
      mem_ready = 1'b0;
      check_eq("arb_gnt_pulse", {if_gnt, d_gnt}, 2'b00);
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();
    tick();

    // Timeout: ready withheld
    d_req = 1'b1; d_addr = 32'h80;
    tick();                                    // BUSY 1
    check_eq("to_gnt", d_gnt, 1'b1);
    d_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();                                  // BUSY 2..4
      check_eq("to_busy", {err, mem_req}, 2'b01);
    end
    tick();
    check_eq("to_err", {err, mem_req, d_rvalid, if_rvalid}, 4'b1000);
    mem_ready = 1'b1;
    tick();
    tick();
    mem_ready = 1'b0;
    check_eq("to_norv", {err, d_rvalid, if_rvalid}, 3'b100);
    if_req = 1'b1; if_addr = 32'h44;
    tick();
    check_eq("to_idle_gnt", if_gnt, 1'b1);
    if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hCAFE_0001;
    tick();
    mem_ready = 1'b0;
    tick();
    check_eq("to_sticky", {err, if_rvalid}, 2'b11);
    do_reset();
    check_eq("to_clr", err, 1'b0);

    // Reset pulsed mid-BUSY
    if_req = 1'b1; if_addr = 32'h30;
    tick();
    check_eq("ab_gnt", if_gnt, 1'b1);
    if_req = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("ab_outs", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, err}, 6'b0);
    check_eq("ab_rdata", if_rdata, 32'h0);
    mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("ab_norv", {if_rvalid, d_rvalid, mem_req}, 3'b000);
    end
    mem_ready = 1'b0;
    if_req = 1'b1; if_addr = 32'h20;
    tick();
    check_eq("ab_next_gnt", {if_gnt, mem_req}, 2'b11);
    check_eq("ab_next_addr", mem_addr, 32'h20);
    if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ready = 1'b0;
    tick();
    check_eq("ab_next_rv", if_rvalid, 1'b1);
    check_eq("ab_next_data", if_rdata, 32'h1234_5678);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32: address width.
REQ-002 SHALL have parameter DW, default 32: data width.
REQ-003 SHALL have parameter TIMEOUT, default 16: maximum BUSY cycles allowed before an error is flagged.
REQ-004 SHALL have port clk  in  1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1: reset, synchronous, active-high.
REQ-006 SHALL have ports if_req in 1 and if_addr in AW: fetch-port read request; held stable until if_gnt.
REQ-007 SHALL have ports if_gnt out 1 and if_rvalid out 1: fetch accept pulse and fetch response pulse.
REQ-008 SHALL have port if_rdata  out  DW: fetch read data; valid only while if_rvalid.
REQ-009 SHALL have ports d_req in 1, d_we in 1, d_addr in AW, d_wdata in DW, d_be in DW/8: data-port request; held stable until d_gnt.
REQ-010 SHALL have ports d_gnt out 1, d_rvalid out 1, d_rdata out DW: data accept, response (read data or write ack), read data.
REQ-011 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out AW, mem_wdata out DW, mem_be out DW/8: single-port memory command.
REQ-012 SHALL have ports mem_ready in 1 and mem_rdata in DW: memory completion pulse and read data.
REQ-013 SHALL have port err  out  1: sticky timeout flag.

Function
REQ-014 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE, one transaction in flight.
REQ-015 SHALL, in IDLE with any request, latch winner's command into mem_* registers, enter BUSY, and pulse winner's gnt for exactly one cycle.
REQ-016 SHALL hold mem_req high and mem_* stable throughout BUSY; mem_req low in IDLE and RESP.
REQ-017 SHALL, on a BUSY cycle with mem_ready=1, capture mem_rdata into the owner's rdata register and enter RESP.
REQ-018 SHALL pulse the owner's rvalid for exactly one cycle in RESP, writes included; the non-owner's gnt/rvalid stay 0.
REQ-019 SHALL give minimum latency request-to-rvalid of 3 cycles, with mem_ready asserted in the first BUSY cycle.
REQ-020 SHALL ignore mem_ready outside BUSY.
REQ-021 SHALL drive mem_we=0 and mem_be=all-ones for fetch transactions.
REQ-022 SHALL count BUSY cycles (saturating); when the count reaches TIMEOUT without mem_ready: set err, return to IDLE, issue no rvalid.
REQ-023 SHALL keep err set until reset.
REQ-024 SHALL hold rdata registers between transactions; they are not cleared on rvalid.
REQ-025 SHALL, with both requests in IDLE, arbitrate per REQ-029/030; a lone request is always served.
REQ-026 SHALL evaluate a request arriving in RESP or BUSY only on the next IDLE cycle.

Reset
REQ-027 SHALL, with rst high at a clock edge, force IDLE, clear all gnt/rvalid/mem_req/mem_we/err/counter/last-owner state, and zero mem_addr, mem_wdata, if_rdata and d_rdata.
REQ-028 SHALL abort any in-flight transaction on reset mid-operation: no rvalid follows, and a later mem_ready is ignored.

Configuration
REQ-029 SHALL, with MEM_ARB_FAIRNESS_EN defined, alternate on simultaneous requests: grant the port not served last (last-owner bit; data wins first after reset).
REQ-030 SHALL, without MEM_ARB_FAIRNESS_EN, always give data port priority on simultaneous requests; no last-owner state is synthesized.

Structure
REQ-031 SHALL take the FSM state encoding (IDLE/BUSY/RESP) and the owner encoding (OWN_IF/OWN_D) from the shared pipeline package.
REQ-032 SHALL contain one sub-module, mem_arb_timer: BUSY counter with saturate, clear and expired outputs.

Verification
REQ-033 SHALL cover: fetch read, if_addr=0x00000010, mem_ready in 1st BUSY cycle, mem_rdata=0x00500093 -> if_gnt in cycle 1, if_rvalid in cycle 3, if_rdata=0x00500093.
REQ-034 SHALL cover: data write, d_addr=0x00000040, d_wdata=0xDEADBEEF, d_be=0xF -> mem_we=1 with matching mem_*, then d_rvalid one pulse, if_rvalid=0.
REQ-035 SHALL cover: if_req and d_req held high for 4 transactions -> grant order D,IF,D,IF with the macro, and D,D,D,D without it.
REQ-036 SHALL cover: mem_ready withheld, TIMEOUT=4 -> err=1 after 4 BUSY cycles, FSM back in IDLE, no rvalid; err stays 1 until rst.
REQ-037 SHALL cover: rst pulsed in BUSY, then mem_ready=1 -> all outputs 0 after reset, no rvalid, next request served normally.
